multicycle_cpu: RTL
===================

# multicycle_cpu

Parametrised multi-cycle MIPS-subset core, the successor to the single-cycle CPU. It executes each instruction as a sequence of FSM states and uses one shared instruction/data memory over a ready/valid-style bus with arbitrary wait states. It owns the PC, IR, a 32×32 register file, and the ALU/branch datapath. It exposes retire, halt and debug register-read ports for the bench.

## Interface
- `ADDR_W`, default 32: memory address width; `mem_addr_o` = `pc`/effective address `[ADDR_W-1:0]` with bits `[1:0]` forced 0.
- `RESET_PC`, default 32'h0: PC value loaded on reset.
- `clk_i`, in, 1: clock; all state changes on rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `mem_req_o`, out, 1: memory access request.
- `mem_we_o`, out, 1: 1 = store, 0 = read.
- `mem_addr_o`, out, `ADDR_W`: word-aligned byte address.
- `mem_wdata_o`, out, 32: store data.
- `mem_rdata_i`, in, 32: read data, valid when `mem_ready_i`=1.
- `mem_ready_i`, in, 1: access completes in any cycle where `mem_req_o` & `mem_ready_i`.
- `pc_o`, out, 32: current PC.
- `retire_o`, out, 1: one-cycle pulse in the last cycle of each instruction.
- `halted_o`, out, 1: core stopped.
- `illegal_o`, out, 1: halt caused by an unsupported encoding.
- `dbg_raddr_i`, in, 5: debug register index.
- `dbg_rdata_o`, out, 32: combinational read of `reg[dbg_raddr_i]`.

## Operation
- ISA (MIPS encoding):
  - R-type op 0, funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
  - addi 0x08, slti 0x0A (sign-extended imm).
  - lw 0x23, sw 0x2B: address = rs + sext(imm).
  - beq 0x04, bne 0x05.
  - j 0x02.
- Any other op/funct: enter HALT with `illegal_o`=1.
- Register 0 reads 0; writes to it are discarded. Arithmetic wraps mod 2^32, with no overflow trap.
- FSM states and transitions:
  - FETCH: request at `pc`. On ready, load IR, set pc ← pc+4, go to DECODE.
  - DECODE: read rs/rt, check legality. Illegal → HALT.
  - EXEC:
    - ALU ops → WB.
    - lw/sw → MEM.
    - beq/bne: if taken, pc ← pc+4+(sext(imm)<<2); retire; go to FETCH.
    - j: pc ← {pc[31:28], target, 2'b00}; retire; go to FETCH.
  - MEM: request at the effective address; `mem_we_o`=1 for sw with `mem_wdata_o`=rt. On ready: lw → WB (rdata latched); sw → retire, go to FETCH.
  - WB: write rd (R-type) or rt (addi/slti/lw); retire; go to FETCH.
  - HALT: absorbing; exit only by reset.
- Branch offset uses the already-incremented PC. Low two address bits are ignored; there is no misalignment fault.

## Timing
- Reset values while `rst_i`=0, applied immediately:
  - pc = `RESET_PC`, all registers 0, IR 0, state FETCH.
  - `mem_req_o`=0, `mem_we_o`=0, `retire_o`=0, `halted_o`=0, `illegal_o`=0.
  - `mem_addr_o`/`mem_wdata_o` = 0.
- First request is asserted in the first cycle after `rst_i` rises.
- `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are decoded from registered state. They are held stable from request assertion until the ready cycle. `mem_req_o` drops the cycle after completion.
- `mem_ready_i` is ignored when `mem_req_o`=0.
- Zero-wait-state latency, in cycles: ALU op 4, lw 5, sw 4, branch/jump 3. Each wait cycle adds 1 per memory access.
- `retire_o` is high in the final state cycle. Register/PC updates become visible the following cycle.
- `dbg_rdata_o` reflects writes from the cycle after WB.
- Reset mid-access aborts immediately: no register or memory write completes, and `mem_req_o` falls asynchronously.
- HALT:
  - `mem_req_o` stays 0 and `retire_o` stays 0.
  - pc holds the address of the halting instruction + 4.
  - `halted_o` and `illegal_o` assert in the cycle after DECODE.

## Test plan
- Reset: hold `rst_i`=0 mid-fetch → outputs at reset values, `pc_o`=0. Release → `mem_req_o`=1, `mem_addr_o`=0 next cycle.
- ALU chain, `mem_ready_i` tied 1: 0x20010005 (addi $1,5), 0x20020007 (addi $2,7), 0x00221820 (add $3,$1,$2) → `retire_o` at cycles 4, 8, 12; `dbg` reg3 = 12. Also: addi $0,$0,5 leaves reg0 = 0.
- Memory ops with $3=12:
  - 0xAC030040 (sw) → one cycle with `mem_we_o`=1, addr 0x40, wdata 12.
  - 0x8C040040 (lw), rdata 12 → reg4 = 12; instruction takes 5 cycles.
- Branches with $1=5, $2=7:
  - 0x14220002 (bne) at pc 0x10 → next fetch at 0x1C.
  - 0x10220002 (beq) at pc 0x10 → next fetch at 0x14.
  - 0x08000040 (j) → next fetch at 0x100.
- Wait states: `mem_ready_i` low for 3 cycles during FETCH and 2 during lw MEM → request signals stable throughout; lw retires after 10 cycles; result unchanged.
- Illegal: 0xFC000000 at pc 0x8 → `halted_o`=`illegal_o`=1, `pc_o`=0xC, no further `mem_req_o` for 20 cycles; reset clears it.

Source files
------------

// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core: one shared memory port with wait states, six-state FSM,
// 32x32 register file, and retire/halt/debug observation ports.
module multicycle_cpu #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ready_i,
    output logic [31:0]       pc_o,
    output logic              retire_o,
    output logic              halted_o,
    output logic              illegal_o,
    input  logic [4:0]        dbg_raddr_i,
    output logic [31:0]       dbg_rdata_o
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] rf_q [32];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        retire;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic        legal;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] imm_sext;

    assign op       = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

    always_comb begin
        legal = 1'b0;
        case (op)
            OpRtype: legal = (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
                             (funct == FnOr)  || (funct == FnSlt);
            OpJ, OpBeq, OpBne, OpAddi, OpSlti, OpLw, OpSw: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        retire   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;

        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready_i) begin
                    ir_d    = mem_rdata_i;
                    pc_d    = pc_q + 32'd4;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d     = rf_q[ir_q[25:21]];
                b_d     = rf_q[ir_q[20:16]];
                state_d = legal ? StExec : StHalt;
            end
            StExec: begin
                state_d = StWb;
                case (op)
                    OpRtype: begin
                        case (funct)
                            FnSub:   alu_d = a_q - b_q;
                            FnAnd:   alu_d = a_q & b_q;
                            FnOr:    alu_d = a_q | b_q;
                            FnSlt:   alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
                            default: alu_d = a_q + b_q;
                        endcase
                    end
                    OpSlti: alu_d = {31'd0, $signed(a_q) < $signed(imm_sext)};
                    OpLw, OpSw: begin
                        alu_d   = a_q + imm_sext;
                        state_d = StMem;
                    end
                    OpBeq, OpBne: begin
                        // pc_q already points past the branch
                        if ((a_q == b_q) == (op == OpBeq)) begin
                            pc_d = pc_q + {imm_sext[29:0], 2'b00};
                        end
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    OpJ: begin
                        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    default: alu_d = a_q + imm_sext;
                endcase
            end
            StMem: begin
                mem_req  = 1'b1;
                mem_we   = (op == OpSw);
                mem_addr = alu_q;
                if (mem_ready_i) begin
                    if (op == OpSw) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        mdr_d   = mem_rdata_i;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_we    = 1'b1;
                rf_waddr = (op == OpRtype) ? ir_q[15:11] : ir_q[20:16];
                rf_wdata = (op == OpLw) ? mdr_q : alu_q;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            if (rf_we && (rf_waddr != 5'd0)) begin
                rf_q[rf_waddr] <= rf_wdata;
            end
        end
    end

    // Gating with rst_i drops the request asynchronously when reset hits mid-access.
    assign mem_req_o   = rst_i & mem_req;
    assign mem_we_o    = mem_req_o & mem_we;
    assign mem_addr_o  = mem_req_o ? ADDR_W'(mem_addr & 32'hFFFF_FFFC) : '0;
    assign mem_wdata_o = mem_we_o ? b_q : '0;
    assign retire_o    = rst_i & retire;
    assign pc_o        = pc_q;
    assign halted_o    = (state_q == StHalt);
    // An illegal encoding is the only way into HALT.
    assign illegal_o   = (state_q == StHalt);
    assign dbg_rdata_o = rf_q[dbg_raddr_i];

endmodule
